// File: rtl/add_multicycle.sv
// ============================================================================
// Module   : add_multicycle
// Brief    : Adds or subtracts CHUNK bits per clock and reports carry and overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_multicycle #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int c_n     = WIDTH / CHUNK;
    localparam int c_cnt_w = (c_n > 1) ? $clog2(c_n) : 1;
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(c_n - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_carry;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_acc;

    logic [CHUNK:0]       w_chunk_sum;
    logic [WIDTH+CHUNK-1:0] w_cat;
    logic [WIDTH-1:0]     w_next_acc;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_msb_carry_in;

    // Operands are shifted right each cycle, so the active chunk is always the low bits.
    assign w_chunk_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, r_carry};

    // Partial sums enter at the top and migrate down; after N steps chunk 0 sits at bit 0.
    assign w_cat      = {w_chunk_sum[CHUNK-1:0], r_acc};
    assign w_next_acc = w_cat[WIDTH+CHUNK-1:CHUNK];

    assign w_last   = (r_cnt == c_last);
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Carry into the MSB recovered from the MSB's own sum bit and operand bits.
    assign w_msb_carry_in = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_chunk_sum[CHUNK-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= c_in ^ sub;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_carry <= w_chunk_sum[CHUNK];
                    r_acc   <= w_next_acc;
                    if (w_last) begin
                        sum     <= w_next_acc;
                        c_out   <= w_chunk_sum[CHUNK];
                        ovf     <= w_msb_carry_in ^ w_chunk_sum[CHUNK];
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/add_multicycle.md
ADD_MULTICYCLE -- requirements
Module: add_multicycle

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits.
REQ-002 Parameter: CHUNK, 2, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request a new operation; sampled only when accepted (REQ-011).
REQ-006 sub  input  1  0 = add, 1 = subtract; captured with start.
REQ-007 a  input  WIDTH  operand A; captured with start.
REQ-008 b  input  WIDTH  operand B; captured with start.
REQ-009 c_in  input  1  carry-in (add) or borrow-in (sub); captured with start.
REQ-010 Outputs: busy (1, operation in progress); done (1, one-cycle completion pulse); sum (WIDTH, result); c_out (1, carry out of MSB); ovf (1, signed two's-complement overflow).

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE, and start SHALL be accepted only in IDLE or DONE; start in RUN SHALL be ignored without side effects.
REQ-012 On acceptance, the block SHALL capture a, b XOR {WIDTH{sub}} and initial carry c_in XOR sub, clear a chunk counter to 0, and enter RUN.
REQ-013 Result: sub=0 gives a+b+c_in; sub=1 gives a-b-c_in, computed modulo 2^WIDTH.
REQ-014 In RUN, each cycle SHALL add chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) of the captured operands plus the registered carry, store CHUNK partial-sum bits and the new carry, and increment k.
REQ-015 After the edge that processes chunk N-1, the FSM SHALL enter DONE; done SHALL then be 1 for exactly that one cycle.
REQ-016 Latency: done SHALL assert exactly N cycles after the edge that accepted start.
REQ-017 busy SHALL be 1 in RUN only, and 0 in IDLE and DONE.
REQ-018 sum, c_out and ovf SHALL update only on entry to DONE and SHALL hold until the next entry to DONE or reset; partial results SHALL NOT be visible.
REQ-019 c_out SHALL be the raw carry out of bit WIDTH-1; for sub, 1 means no borrow.
REQ-020 ovf SHALL equal (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-021 DONE SHALL go to RUN if start=1 (back-to-back operation, no idle bubble) and to IDLE otherwise.
REQ-022 Changes on a, b, sub or c_in while in RUN SHALL NOT affect the result in progress.
REQ-023 When CHUNK=WIDTH (N=1), RUN SHALL last one cycle and done SHALL assert 1 cycle after acceptance.

Reset
REQ-024 rst=1 SHALL immediately force IDLE with busy=0, done=0, sum=0, c_out=0, ovf=0, and clear the chunk counter and the carry register.
REQ-025 rst asserted during RUN SHALL abandon the operation; no done pulse SHALL follow after rst is released.
REQ-026 The first rising edge after rst deasserts SHALL be able to accept start.

Verification (WIDTH=8, CHUNK=2, N=4)
REQ-027 Add: a=0x5A, b=0x3C, c_in=0, sub=0 -> done at 4 cycles after acceptance, sum=0x96, c_out=0, ovf=1; busy high for exactly 4 cycles.
REQ-028 Subtract: a=0x10, b=0x20, c_in=0, sub=1 -> sum=0xF0, c_out=0, ovf=0.
REQ-029 Carry chain: a=0xFF, b=0x01, c_in=1, sub=0 -> sum=0x01, c_out=1, ovf=0; subtract a=0x80, b=0x01, sub=1 -> sum=0x7F, c_out=1, ovf=1.
REQ-030 Ignore/hold: start=1 with new operands on RUN cycle 2 -> first result unchanged and no extra operation; inputs toggled randomly during RUN -> result unchanged.
REQ-031 Back-to-back: start=1 during the DONE cycle with a=0x01, b=0x01 -> busy on the next cycle, second done 4 cycles later with sum=0x02; previous sum held until then.
REQ-032 Reset mid-op: rst pulsed in RUN cycle 2 -> all outputs 0 immediately, no done afterward; rerun with CHUNK=8 -> done 1 cycle after start.
